// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit seven-segment scan driver with a tear-free single-slot load path.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 49999
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_dp,
  output logic [7:0]  digit,
  output logic [7:0]  seg_data,
  output logic        frame_done
);

  localparam int PW = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1;

  logic [PW-1:0] presc_r;
  logic [2:0]    idx_r;
  logic [31:0]   disp_data_r;
  logic [7:0]    disp_dp_r;
  logic [31:0]   pend_data_r;
  logic [7:0]    pend_dp_r;
  logic          pend_full_r;

  logic          tick_s;
  logic          frame_end_s;
  logic          load_fire_s;
  logic          commit_s;
  logic [3:0]    nib_s;
  logic          dp_sel_s;
  logic          blank_s;

  function automatic logic [6:0] seg7_f(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h7E;
      4'h1:    code = 7'h30;
      4'h2:    code = 7'h6D;
      4'h3:    code = 7'h79;
      4'h4:    code = 7'h33;
      4'h5:    code = 7'h5B;
      4'h6:    code = 7'h5F;
      4'h7:    code = 7'h70;
      4'h8:    code = 7'h7F;
      4'h9:    code = 7'h7B;
      4'hA:    code = 7'h77;
      4'hB:    code = 7'h1F;
      4'hC:    code = 7'h4E;
      4'hD:    code = 7'h3D;
      4'hE:    code = 7'h4F;
      4'hF:    code = 7'h47;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

`ifdef SEG_LZ_BLANK_EN
  // True when every nibble from the leftmost up to and including idx is zero.
  function automatic logic lead_zero_f(input logic [31:0] data, input logic [2:0] idx);
    logic z;
    z = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((i <= int'(idx)) && (data[31-4*i -: 4] != 4'h0)) begin
        z = 1'b0;
      end
    end
    return z;
  endfunction
`endif

  assign tick_s      = (presc_r == PW'(REFRESH_DIV));
  assign frame_end_s = tick_s && (idx_r == 3'd7);
  assign load_fire_s = load_valid && !pend_full_r;
  assign commit_s    = frame_end_s && pend_full_r;

  assign load_ready  = !pend_full_r;
  assign frame_done  = frame_end_s;
  assign digit       = 8'h80 >> idx_r;

  // Prescaler and digit scan position.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      presc_r <= '0;
      idx_r   <= 3'd0;
    end else if (tick_s) begin
      presc_r <= '0;
      idx_r   <= idx_r + 3'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Pending slot capture and frame-boundary commit into the display register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pend_data_r <= 32'h0;
      pend_dp_r   <= 8'h00;
      pend_full_r <= 1'b0;
      disp_data_r <= 32'h0;
      disp_dp_r   <= 8'h00;
    end else if (commit_s) begin
      disp_data_r <= pend_data_r;
      disp_dp_r   <= pend_dp_r;
      pend_full_r <= 1'b0;
    end else if (load_fire_s) begin
      pend_data_r <= load_data;
      pend_dp_r   <= load_dp;
      pend_full_r <= 1'b1;
    end
  end

  // Segment decode for the currently selected digit.
  always_comb begin
    nib_s    = disp_data_r[{~idx_r, 2'b00} +: 4];
    dp_sel_s = disp_dp_r[~idx_r];
    blank_s  = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    if ((idx_r != 3'd7) && !dp_sel_s && lead_zero_f(disp_data_r, idx_r)) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
`endif
    if (blank_s) begin
      seg_data = 8'h00;
    end else begin
      seg_data = {seg7_f(nib_s), dp_sel_s};
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver (REFRESH_DIV=3) against a frame-time reference model.
module tb_seg_scan_driver;

  logic        clk;
  logic        rstb;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic [7:0]  load_dp;
  logic [7:0]  digit;
  logic [7:0]  seg_data;
  logic        frame_done;

  int vectors;
  int miscompares;

  // Reference state: cycles since reset release, shown value, pending value.
  int          m_cyc;
  logic [31:0] m_disp_d;
  logic [7:0]  m_disp_dp;
  logic [31:0] m_pend_d;
  logic [7:0]  m_pend_dp;
  logic        m_full;

  logic [6:0] seg_tab [16];

  seg_scan_driver #(.REFRESH_DIV(3)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .digit      (digit),
    .seg_data   (seg_data),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, m_cyc);
    end
  endtask

  function automatic logic [7:0] exp_seg(input logic [31:0] d, input logic [7:0] dp, input int idx);
    logic [31:0] left;
    logic [7:0]  v;
    left = d >> (4 * (7 - idx));
    v = {seg_tab[left[3:0]], dp[7-idx]};
`ifdef SEG_LZ_BLANK_EN
    if (idx != 7 && dp[7-idx] == 1'b0 && left == 32'h0) v = 8'h00;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_disp_d = 32'h0; m_disp_dp = 8'h00;
    m_pend_d = 32'h0; m_pend_dp = 8'h00; m_full = 1'b0;
  endtask

  task automatic model_step();
    if ((m_cyc % 32) == 31 && m_full) begin
      m_disp_d = m_pend_d; m_disp_dp = m_pend_dp; m_full = 1'b0;
    end else if (load_valid && !m_full) begin
      m_pend_d = load_data; m_pend_dp = load_dp; m_full = 1'b1;
    end
    m_cyc++;
  endtask

  task automatic check_outputs();
    int idx;
    idx = (m_cyc / 4) % 8;
    check_eq("digit",      {24'h0, digit},      {24'h0, 8'h80 >> idx});
    check_eq("seg_data",   {24'h0, seg_data},   {24'h0, exp_seg(m_disp_d, m_disp_dp, idx)});
    check_eq("frame_done", {31'h0, frame_done}, {31'h0, rstb && ((m_cyc % 32) == 31)});
    check_eq("load_ready", {31'h0, load_ready}, {31'h0, !m_full});
  endtask

  task automatic drive_random();
    int sel;
    load_valid = ($urandom_range(0, 3) == 0);
    sel = $urandom_range(0, 6);
    case (sel)
      0:       load_data = 32'h0000_0000;
      1:       load_data = 32'h0000_0120;
      2:       load_data = 32'h1234_ABCD;
      3:       load_data = 32'hFFFF_FFFF;
      4:       load_data = $urandom >> $urandom_range(4, 28);
      default: load_data = $urandom;
    endcase
    load_dp = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
  endtask

  initial begin
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    vectors = 0; miscompares = 0;
    rstb = 1'b0; load_valid = 1'b0; load_data = 32'h0; load_dp = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rstb = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      if (rstb) model_step();
      @(negedge clk);
      check_outputs();
      if (!rstb) begin
        rstb = 1'b1;
        load_valid = 1'b0;
      end else if ((n % 700) == 350) begin
        rstb = 1'b0;
        load_valid = 1'b0;
        model_reset();
      end else if ((n % 700) == 349) begin
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        load_dp    = 8'hA5;
      end else begin
        drive_random();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
